// File: rtl/axis_img_border_gen.sv
// axis_img_border_gen: pads a 16-bit AXIS frame with BORDER constant pixels and tags originals; err_cnt under AXIS_IMG_BORDER_GEN_ERR_CNT_EN.
// Latency: 1 cycle input to output, one beat per clock when unstalled, plus one start cycle per frame.
// Backpressure: m_axis_* hold and s_axis_tready drops while m_axis_tvalid & ~m_axis_tready.
module axis_img_border_gen #(
    parameter int          IMG_WIDTH       = 640,
    parameter int          IMG_HEIGHT      = 512,
    parameter int          BORDER          = 2,
    parameter logic [15:0] BYPASS_BIT_MASK = 16'h4000,
    parameter logic [15:0] BORDER_VALUE    = 16'h0000
) (
    input  logic        axis_aclk,
    input  logic        axis_aresetn,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [15:0] err_cnt
);
    localparam int OW = IMG_WIDTH + 2 * BORDER;
    localparam int OH = IMG_HEIGHT + 2 * BORDER;
    localparam int CW = $clog2(OW);
    localparam int RW = $clog2(OH);

    localparam logic [CW-1:0] COL_ONE     = CW'(1);
    localparam logic [CW-1:0] COL_LAST    = CW'(OW - 1);
    localparam logic [CW-1:0] COL_LO      = CW'(BORDER);
    localparam logic [CW-1:0] COL_HI      = CW'(BORDER + IMG_WIDTH);
    localparam logic [CW-1:0] COL_IN_LAST = CW'(BORDER + IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_ONE     = RW'(1);
    localparam logic [RW-1:0] ROW_LAST    = RW'(OH - 1);
    localparam logic [RW-1:0] ROW_LO      = RW'(BORDER);
    localparam logic [RW-1:0] ROW_HI      = RW'(BORDER + IMG_HEIGHT);

    typedef enum logic {ST_IDLE, ST_SCAN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] col, col_nxt;
    logic [RW-1:0] row, row_nxt;
    logic [15:0]   tdata_nxt;
    logic          tvalid_nxt, tlast_nxt, tuser_nxt;
    logic          adv, interior, load;

    assign adv      = !m_axis_tvalid || m_axis_tready;
    assign interior = (row >= ROW_LO) && (row < ROW_HI) && (col >= COL_LO) && (col < COL_HI);

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state         <= ST_IDLE;
            col           <= '0;
            row           <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else begin
            state         <= state_nxt;
            col           <= col_nxt;
            row           <= row_nxt;
            m_axis_tdata  <= tdata_nxt;
            m_axis_tvalid <= tvalid_nxt;
            m_axis_tlast  <= tlast_nxt;
            m_axis_tuser  <= tuser_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        col_nxt       = col;
        row_nxt       = row;
        tdata_nxt     = m_axis_tdata;
        tvalid_nxt    = m_axis_tvalid;
        tlast_nxt     = m_axis_tlast;
        tuser_nxt     = m_axis_tuser;
        s_axis_tready = 1'b0;
        load          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (m_axis_tready) tvalid_nxt = 1'b0;
                // Start-of-frame beat is left on the bus for the first interior slot.
                s_axis_tready = s_axis_tvalid && !s_axis_tuser;
                if (s_axis_tvalid && s_axis_tuser) begin
                    state_nxt = ST_SCAN;
                    col_nxt   = '0;
                    row_nxt   = '0;
                end
            end
            ST_SCAN: begin
                if (interior) begin
                    s_axis_tready = adv;
                    if (adv && s_axis_tvalid) begin
                        load      = 1'b1;
                        tdata_nxt = s_axis_tdata | BYPASS_BIT_MASK;
                    end else if (adv) begin
                        tvalid_nxt = 1'b0;
                    end
                end else if (adv) begin
                    load      = 1'b1;
                    tdata_nxt = BORDER_VALUE & ~BYPASS_BIT_MASK;
                end
                if (load) begin
                    tvalid_nxt = 1'b1;
                    tuser_nxt  = (row == '0) && (col == '0);
                    tlast_nxt  = (col == COL_LAST);
                    if (col == COL_LAST) begin
                        col_nxt = '0;
                        if (row == ROW_LAST) begin
                            row_nxt   = '0;
                            state_nxt = ST_IDLE;
                        end else begin
                            row_nxt = row + ROW_ONE;
                        end
                    end else begin
                        col_nxt = col + COL_ONE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef AXIS_IMG_BORDER_GEN_ERR_CNT_EN
    logic consumed, err_hit;

    always_comb begin
        consumed = (state == ST_SCAN) && interior && s_axis_tvalid && s_axis_tready;
        err_hit  = (consumed && ((s_axis_tlast != (col == COL_IN_LAST)) ||
                                 (s_axis_tuser && !((row == ROW_LO) && (col == COL_LO))))) ||
                   ((state == ST_IDLE) && s_axis_tvalid && !s_axis_tuser);
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            err_cnt <= '0;
        end else if (err_hit && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
    assign err_cnt      = 16'h0000;
`endif

endmodule

// File: tb/tb_axis_img_border_gen.sv
// Bench for axis_img_border_gen: random frames through a padded-frame reference model, scoreboard-checked.
module tb_axis_img_border_gen;
    localparam int          W    = 4;
    localparam int          H    = 3;
    localparam int          B    = 1;
    localparam logic [15:0] MASK = 16'h4000;
    localparam logic [15:0] BV   = 16'h0123;
    localparam int          OW   = W + 2 * B;
    localparam int          OH   = H + 2 * B;
    localparam int          NB   = OW * OH;

    logic        axis_aclk = 1'b0;
    logic        axis_aresetn = 1'b0;
    logic [15:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic [15:0] err_cnt;

    axis_img_border_gen #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .BORDER(B),
        .BYPASS_BIT_MASK(MASK), .BORDER_VALUE(BV)
    ) dut (
        .axis_aclk(axis_aclk), .axis_aresetn(axis_aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .err_cnt(err_cnt)
    );

    always #5 axis_aclk = ~axis_aclk;

    typedef struct packed {
        logic [15:0] dat;
        logic        last;
        logic        user;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] frame_pix[W*H];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          total_beats = 0;
    int          beat_idx = 0;
    int          sof_cyc = 0;
    int          sof_prev = 0;
    int          eof_cyc = 0;
    int          exp_err = 0;
    int          rdy_mode = 0;
    bit          vld_rand = 1'b0;
    bit          abort = 1'b0;

    always @(posedge axis_aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_err(input string name);
`ifdef AXIS_IMG_BORDER_GEN_ERR_CNT_EN
        chk(name, 32'(err_cnt), 32'(exp_err));
`else
        chk(name, 32'(err_cnt), 32'd0);
`endif
    endtask

    // Reference: the padded frame built directly from the pixel array.
    task automatic push_expected();
        beat_t e;
        for (int r = 0; r < OH; r++) begin
            for (int c = 0; c < OW; c++) begin
                if (r >= B && r < B + H && c >= B && c < B + W)
                    e.dat = frame_pix[(r - B) * W + (c - B)] | MASK;
                else
                    e.dat = BV & ~MASK;
                e.last = (c == OW - 1);
                e.user = (r == 0 && c == 0);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic random_frame();
        for (int i = 0; i < W * H; i++) frame_pix[i] = 16'($urandom);
    endtask

    task automatic send_beat(input logic [15:0] d, input logic u, input logic l);
        int n;
        if (vld_rand) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge axis_aclk);
                #1;
            end
        end
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge axis_aclk);
            if (abort) break;
            if (s_axis_tready) begin
                @(posedge axis_aclk);
                #1;
                break;
            end
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: s_axis_tready low for %0d cycles, expected a handshake", n);
                break;
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drive_frame(input bit short_line);
        logic u, l;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                u = (r == 0 && c == 0);
                l = (short_line && r == 0) ? (c == W - 2) : (c == W - 1);
                if ((l != (c == W - 1)) || (u != (r == 0 && c == 0))) exp_err++;
                send_beat(frame_pix[r * W + c], u, l);
                if (abort) return;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge axis_aclk);
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge axis_aclk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge axis_aclk);
            #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: beats and stall stability, sampled on the falling edge.
    initial begin
        beat_t e, held;
        bit    stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge axis_aclk);
            if (!axis_aresetn) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                chk("hold_data", 32'(m_axis_tdata), 32'(held.dat));
                chk("hold_ctl", {29'd0, m_axis_tvalid, m_axis_tlast, m_axis_tuser},
                    {29'd0, 1'b1, held.last, held.user});
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h, expected no beat", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(m_axis_tdata), 32'(e.dat));
                    chk("beat_last", 32'(m_axis_tlast), 32'(e.last));
                    chk("beat_user", 32'(m_axis_tuser), 32'(e.user));
                end
                if (m_axis_tuser) begin
                    sof_prev = sof_cyc;
                    sof_cyc  = cyc;
                    beat_idx = 0;
                end else begin
                    beat_idx++;
                end
                if (beat_idx == NB - 1) eof_cyc = cyc;
                total_beats++;
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            held    = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
        end
    end

    initial begin
        int base, n;
        #23;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
        chk("rst_tlast_tuser", {30'd0, m_axis_tlast, m_axis_tuser}, 32'd0);
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        chk_err("rst_err_cnt");
        @(posedge axis_aclk);
        #1 axis_aresetn = 1'b1;

        // Streaming, pixels 1..12, full rate.
        for (int i = 0; i < W * H; i++) frame_pix[i] = 16'(i + 1);
        push_expected();
        drive_frame(1'b0);
        wait_drain("stream_drain");
        chk("stream_span", 32'(eof_cyc - sof_cyc), 32'(NB - 1));
        chk_err("stream_err_cnt");

        // Backpressure: toggling, then random ready, random input gaps.
        vld_rand = 1'b1;
        for (int m = 1; m <= 2; m++) begin
            rdy_mode = m;
            random_frame();
            push_expected();
            drive_frame(1'b0);
            wait_drain("bp_drain");
        end
        rdy_mode = 0;
        vld_rand = 1'b0;
        chk_err("bp_err_cnt");

        // Stray pixels in IDLE are dropped.
        for (int i = 0; i < 3; i++) begin
            send_beat(16'($urandom), 1'b0, 1'b0);
            exp_err++;
        end
        random_frame();
        push_expected();
        drive_frame(1'b0);
        wait_drain("flush_drain");
        chk_err("flush_err_cnt");

        // Early tlast on the first line.
        random_frame();
        push_expected();
        drive_frame(1'b1);
        wait_drain("tlast_err_drain");
        chk_err("tlast_err_cnt");

        // Back-to-back frames.
        random_frame();
        push_expected();
        drive_frame(1'b0);
        random_frame();
        push_expected();
        drive_frame(1'b0);
        wait_drain("b2b_drain");
        chk("b2b_sof_gap", 32'(sof_cyc - sof_prev), 32'(NB + 1));

        // Reset after 10 output beats.
        base = total_beats;
        random_frame();
        push_expected();
        fork
            drive_frame(1'b0);
            begin
                n = 0;
                while (total_beats < base + 10 && n < 1000) begin
                    @(negedge axis_aclk);
                    #1;
                    n++;
                end
                chk("rst_mid_reached", 32'(total_beats - base >= 10), 32'd1);
                @(posedge axis_aclk);
                #2;
                axis_aresetn = 1'b0;
                abort = 1'b1;
                #1;
                chk("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
                chk("mid_rst_tdata", 32'(m_axis_tdata), 32'd0);
                chk("mid_rst_tlast_tuser", {30'd0, m_axis_tlast, m_axis_tuser}, 32'd0);
                chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
                exp_q.delete();
                exp_err = 0;
            end
        join
        @(posedge axis_aclk);
        #1;
        abort = 1'b0;
        axis_aresetn = 1'b1;
        random_frame();
        push_expected();
        drive_frame(1'b0);
        wait_drain("post_rst_drain");
        chk_err("post_rst_err_cnt");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axis_img_border_gen.md
Name: axis_img_border_gen

Overview:
- Stage directly upstream of the image border remover in the DIP/BPR path.
- Takes a raw IMG_WIDTH x IMG_HEIGHT 16-bit AXI4-Stream frame and pads it on all four sides with BORDER pixels of constant value.
- Tags every original pixel with BYPASS_BIT_MASK so the downstream remover keeps only tagged pixels and discards the border after neighbourhood filtering.
- Output frame size is (IMG_WIDTH+2*BORDER) x (IMG_HEIGHT+2*BORDER).

Parameters:
- IMG_WIDTH, 640: input pixels per line.
- IMG_HEIGHT, 512: input lines per frame.
- BORDER, 2: border thickness in pixels on each side (≥1).
- BYPASS_BIT_MASK, 16'h4000: tag bit OR-ed into original pixels.
- BORDER_VALUE, 16'h0000: border pixel value; emitted as BORDER_VALUE & ~BYPASS_BIT_MASK.

Ports:
- axis_aclk  in  1  clock.
- axis_aresetn  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  16  input pixel.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready; combinational.
- s_axis_tlast  in  1  input end of line; checked only, never forwarded.
- s_axis_tuser  in  1  input start of frame.
- m_axis_tdata  out  16  output pixel; registered.
- m_axis_tvalid  out  1  output valid; registered.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output end of padded line; registered.
- m_axis_tuser  out  1  first pixel of padded frame; registered.
- err_cnt  out  16  protocol error counter (see Optional Feature).

Behaviour:
- Reset: asynchronous, active-low. All registered outputs go to 0, err_cnt goes to 0, state goes to ST_IDLE, counters go to 0. Reset mid-frame abandons the frame with no flush.
- Counters: col runs 0..OW-1 and row runs 0..OH-1, where OW=IMG_WIDTH+2*BORDER and OH=IMG_HEIGHT+2*BORDER.
- Interior position: BORDER ≤ row < BORDER+IMG_HEIGHT and BORDER ≤ col < BORDER+IMG_WIDTH.
- adv = ~m_axis_tvalid | m_axis_tready (output register free or draining).
- ST_IDLE:
  - m_axis_tvalid is cleared once accepted.
  - s_axis_tready = s_axis_tvalid & ~s_axis_tuser, so stray mid-frame pixels are dropped.
  - On s_axis_tvalid & s_axis_tuser: go to ST_SCAN with row=col=0. That pixel is not consumed.
- ST_SCAN, border position:
  - If adv: load m_axis_tdata=BORDER_VALUE & ~BYPASS_BIT_MASK and set m_axis_tvalid=1. Advance col/row.
  - s_axis_tready=0.
- ST_SCAN, interior position:
  - s_axis_tready = adv.
  - On s_axis_tvalid & s_axis_tready: load m_axis_tdata = s_axis_tdata | BYPASS_BIT_MASK and set m_axis_tvalid=1. Advance.
  - If adv and no input is available: m_axis_tvalid=0 and the position is held (a bubble).
- On every loaded beat:
  - m_axis_tuser=1 only at row=0, col=0.
  - m_axis_tlast=1 only at col=OW-1.
- Counter advance: col wraps to 0 at OW-1 and row then increments. After loading row=OH-1, col=OW-1, go to ST_IDLE. The last beat stays valid until accepted; IDLE may accept the next tuser in the same cycle.
- Throughput and latency:
  - One pixel per clock when m_axis_tready=1 and the input is always valid.
  - Input-to-output latency is 1 cycle.
  - Per frame: OW*OH output beats for IMG_WIDTH*IMG_HEIGHT input beats.
- Input tdata bits already equal to the tag are forced set. No other masking is applied.
- Backpressure: while m_axis_tvalid & ~m_axis_tready, all m_axis_* outputs hold stable and s_axis_tready=0.
- m_axis_tvalid never depends combinationally on m_axis_tready.

Optional Feature:
- Macro: AXIS_IMG_BORDER_GEN_ERR_CNT_EN.
- Defined:
  - err_cnt is a 16-bit saturating counter (sticks at 16'hFFFF).
  - It increments once per consumed input beat where s_axis_tlast != (col==BORDER+IMG_WIDTH-1).
  - It also increments once per consumed beat with s_axis_tuser=1 at any position other than row=BORDER, col=BORDER.
  - It also increments once per dropped IDLE beat.
  - If several conditions hit the same beat, the counter increments by 1.
  - Cleared only by reset.
- Undefined: err_cnt is tied to 16'h0000, and no checking logic is synthesized.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=3, BORDER=1, BORDER_VALUE=16'h0123, mask 16'h4000):
- Streaming: one frame of pixels 1..12 with correct tuser/tlast, m_axis_tready=1 -> 30 beats. Rows 0 and 4 are all 16'h0123. Row 1 is 0123,4001,4002,4003,4004,0123. tlast on every 6th beat. tuser on beat 0 only. Frame done in 30 cycles after start.
- Backpressure: same frame with m_axis_tready toggling 1/0 and s_axis_tvalid random -> identical 30-beat sequence. Outputs stable while stalled. No input beat lost or duplicated.
- IDLE flush: 3 pixels with tuser=0 then a valid frame -> the 3 pixels are dropped (tready=1 for them). The output frame is as in the streaming case. With the macro, err_cnt=3.
- Errors: frame with tlast on input pixel 3 instead of 4 (macro on) -> output unchanged. err_cnt increments by 2 (pixel 3 and pixel 4 of line 1).
- Reset mid-frame: assert axis_aresetn=0 after 10 output beats -> all outputs 0 asynchronously. After release, the next tuser frame is output completely from beat 0.
- Back-to-back: two frames with no gap -> 60 beats. The second frame's tuser is on beat 30. No idle cycle is required between frames except the 1-cycle start.
